// File: rtl/id_pipe.sv
// ID stage for the logic-class MIPS subset with forwarding, load-use detection and the ID/EX register.
// Latency: one cycle from inst_i to ex_*; read-port and hazard outputs are combinational.
// Backpressure: stall_i holds ID/EX, stallreq_o bubbles it; optional EX/MEM forwarding under `ID_FORWARD_EN.
module id_pipe #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [31:0]       inst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] reg1_data_i,
    input  logic [DATA_W-1:0] reg2_data_i,
    output logic              reg1_read_o,
    output logic              reg2_read_o,
    output logic [4:0]        reg1_addr_o,
    output logic [4:0]        reg2_addr_o,
    input  logic              ex_wreg_i,
    input  logic [4:0]        ex_wd_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              ex_is_load_i,
    input  logic              mem_wreg_i,
    input  logic [4:0]        mem_wd_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              stallreq_o,
    output logic              ex_valid_o,
    output logic [PC_W-1:0]   ex_pc_o,
    output logic [7:0]        ex_aluop_o,
    output logic [2:0]        ex_alusel_o,
    output logic [DATA_W-1:0] ex_reg1_o,
    output logic [DATA_W-1:0] ex_reg2_o,
    output logic [4:0]        ex_wd_o,
    output logic              ex_wreg_o,
    output logic              ex_illegal_o
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;

    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [7:0] ALU_NOP = 8'h00;
    localparam logic [7:0] ALU_AND = 8'b00100100;
    localparam logic [7:0] ALU_OR  = 8'b00100101;
    localparam logic [7:0] ALU_XOR = 8'b00100110;
    localparam logic [7:0] ALU_NOR = 8'b00100111;

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;

    typedef struct packed {
        logic              valid;
        logic [PC_W-1:0]   pc;
        logic [7:0]        aluop;
        logic [2:0]        alusel;
        logic [DATA_W-1:0] reg1;
        logic [DATA_W-1:0] reg2;
        logic [4:0]        wd;
        logic              wreg;
        logic              illegal;
    } idex_t;

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;

    assign op    = inst_i[31:26];
    assign rs    = inst_i[25:21];
    assign rt    = inst_i[20:16];
    assign rd    = inst_i[15:11];
    assign shamt = inst_i[10:6];
    assign funct = inst_i[5:0];

    logic              dec_read1;
    logic              dec_read2;
    logic [4:0]        dec_src1;
    logic [7:0]        dec_aluop;
    logic [2:0]        dec_alusel;
    logic [4:0]        dec_wd;
    logic              dec_wreg;
    logic              dec_illegal;
    logic [DATA_W-1:0] dec_imm;

    always_comb begin
        dec_read1   = 1'b0;
        dec_read2   = 1'b0;
        dec_src1    = rs;
        dec_aluop   = ALU_NOP;
        dec_alusel  = SEL_NOP;
        dec_wd      = rd;
        dec_wreg    = 1'b0;
        dec_illegal = 1'b0;
        dec_imm     = '0;
        if (if_valid_i) begin
            case (op)
                OP_ORI, OP_ANDI, OP_XORI: begin
                    dec_aluop     = (op == OP_ORI)  ? ALU_OR :
                                    (op == OP_ANDI) ? ALU_AND : ALU_XOR;
                    dec_alusel    = SEL_LOGIC;
                    dec_read1     = 1'b1;
                    dec_imm[15:0] = inst_i[15:0];
                    dec_wd        = rt;
                    dec_wreg      = 1'b1;
                end
                OP_LUI: begin
                    // OR with $0 so the EX stage needs no dedicated LUI path
                    dec_aluop                = ALU_OR;
                    dec_alusel               = SEL_LOGIC;
                    dec_read1                = 1'b1;
                    dec_src1                 = 5'd0;
                    dec_imm[DATA_W-1 -: 16]  = inst_i[15:0];
                    dec_wd                   = rt;
                    dec_wreg                 = 1'b1;
                end
                OP_SPECIAL: begin
                    if (inst_i != 32'd0) begin
                        case (funct)
                            FN_AND:  dec_aluop = ALU_AND;
                            FN_OR:   dec_aluop = ALU_OR;
                            FN_XOR:  dec_aluop = ALU_XOR;
                            FN_NOR:  dec_aluop = ALU_NOR;
                            default: dec_illegal = 1'b1;
                        endcase
                        if (shamt != 5'd0) dec_illegal = 1'b1;
                        if (dec_illegal) begin
                            dec_aluop = ALU_NOP;
                        end else begin
                            dec_alusel = SEL_LOGIC;
                            dec_read1  = 1'b1;
                            dec_read2  = 1'b1;
                            dec_wreg   = 1'b1;
                        end
                    end
                end
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    assign reg1_read_o = dec_read1;
    assign reg2_read_o = dec_read2;
    assign reg1_addr_o = rs;
    assign reg2_addr_o = rt;

    function automatic logic [DATA_W-1:0] pick_opnd(
        input logic              rd_en,
        input logic [4:0]        addr,
        input logic [DATA_W-1:0] imm,
        input logic [DATA_W-1:0] rf_dat
    );
        logic [DATA_W-1:0] v;
        if (!rd_en)
            v = imm;
        else if (addr == 5'd0)
            v = '0;
`ifdef ID_FORWARD_EN
        else if (ex_wreg_i && ex_wd_i == addr && !ex_is_load_i)
            v = ex_wdata_i;
        else if (mem_wreg_i && mem_wd_i == addr)
            v = mem_wdata_i;
`endif
        else
            v = rf_dat;
        return v;
    endfunction

    logic [DATA_W-1:0] opnd1;
    logic [DATA_W-1:0] opnd2;

    assign opnd1 = pick_opnd(dec_read1, dec_src1, dec_imm, reg1_data_i);
    assign opnd2 = pick_opnd(dec_read2, rt, dec_imm, reg2_data_i);

    logic hit_ex1;
    logic hit_ex2;

    assign hit_ex1 = dec_read1 && dec_src1 != 5'd0 && ex_wreg_i && ex_wd_i == dec_src1;
    assign hit_ex2 = dec_read2 && rt != 5'd0 && ex_wreg_i && ex_wd_i == rt;

`ifdef ID_FORWARD_EN
    assign stallreq_o = if_valid_i && ex_is_load_i && (hit_ex1 || hit_ex2);
`else
    logic hit_mem1;
    logic hit_mem2;
    logic unused_fwd;

    assign hit_mem1   = dec_read1 && dec_src1 != 5'd0 && mem_wreg_i && mem_wd_i == dec_src1;
    assign hit_mem2   = dec_read2 && rt != 5'd0 && mem_wreg_i && mem_wd_i == rt;
    // without forwarding every in-flight producer must drain first
    assign stallreq_o = if_valid_i && (hit_ex1 || hit_ex2 || hit_mem1 || hit_mem2);
    assign unused_fwd = ^{ex_wdata_i, mem_wdata_i, ex_is_load_i};
`endif

    idex_t ex_q;
    idex_t ex_d;

    always_comb begin
        ex_d = ex_q;
        if (flush_i) begin
            ex_d = '0;
        end else if (stall_i) begin
            ex_d = ex_q;
        end else if (stallreq_o) begin
            ex_d = '0;
        end else begin
            ex_d.valid   = if_valid_i;
            ex_d.pc      = pc_i;
            ex_d.aluop   = dec_aluop;
            ex_d.alusel  = dec_alusel;
            ex_d.reg1    = opnd1;
            ex_d.reg2    = opnd2;
            ex_d.wd      = dec_wd;
            ex_d.wreg    = dec_wreg;
            ex_d.illegal = dec_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    assign ex_valid_o   = ex_q.valid;
    assign ex_pc_o      = ex_q.pc;
    assign ex_aluop_o   = ex_q.aluop;
    assign ex_alusel_o  = ex_q.alusel;
    assign ex_reg1_o    = ex_q.reg1;
    assign ex_reg2_o    = ex_q.reg2;
    assign ex_wd_o      = ex_q.wd;
    assign ex_wreg_o    = ex_q.wreg;
    assign ex_illegal_o = ex_q.illegal;

endmodule

// File: tb/tb_id_pipe.sv
// Directed vector table plus randomized run against a decode-table model of the ID stage.
module tb_id_pipe;

`ifdef ID_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        if_valid_i;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] reg1_data_i;
    logic [31:0] reg2_data_i;
    logic        reg1_read_o;
    logic        reg2_read_o;
    logic [4:0]  reg1_addr_o;
    logic [4:0]  reg2_addr_o;
    logic        ex_wreg_i;
    logic [4:0]  ex_wd_i;
    logic [31:0] ex_wdata_i;
    logic        ex_is_load_i;
    logic        mem_wreg_i;
    logic [4:0]  mem_wd_i;
    logic [31:0] mem_wdata_i;
    logic        stallreq_o;
    logic        ex_valid_o;
    logic [31:0] ex_pc_o;
    logic [7:0]  ex_aluop_o;
    logic [2:0]  ex_alusel_o;
    logic [31:0] ex_reg1_o;
    logic [31:0] ex_reg2_o;
    logic [4:0]  ex_wd_o;
    logic        ex_wreg_o;
    logic        ex_illegal_o;

    id_pipe #(.DATA_W(32), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .pc_i(pc_i), .inst_i(inst_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
        .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
        .stallreq_o(stallreq_o),
        .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_aluop_o(ex_aluop_o), .ex_alusel_o(ex_alusel_o),
        .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o), .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o),
        .ex_illegal_o(ex_illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst, flush, stall, vld;
        logic [31:0] pc, inst, r1, r2;
        logic        exw;
        logic [4:0]  exwd;
        logic [31:0] exdat;
        logic        exld, memw;
        logic [4:0]  memwd;
        logic [31:0] memdat;
    } in_t;

    typedef struct packed {
        logic        stallreq, valid;
        logic [31:0] pc;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] r1, r2;
        logic [4:0]  wd;
        logic        wreg, ill;
    } out_t;

    typedef struct {
        in_t  i;
        out_t e;
    } vec_t;

    localparam logic [31:0] I_ORI  = 32'h342200F0;  // ori  $2,$1,0x00F0
    localparam logic [31:0] I_OR   = 32'h00221825;  // or   $3,$1,$2
    localparam logic [31:0] I_AND  = 32'h00A02024;  // and  $4,$5,$0
    localparam logic [31:0] I_XORI = 32'h38C70001;  // xori $7,$6,1
    localparam logic [31:0] I_LUI  = 32'h3C69ABCD;  // lui  $9,0xABCD with rs=3
    localparam logic [31:0] I_NOR  = 32'h00221827;  // nor  $3,$1,$2
    localparam logic [31:0] I_BAD  = 32'hFC000000;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input in_t x);
        rst = x.rst; flush_i = x.flush; stall_i = x.stall; if_valid_i = x.vld;
        pc_i = x.pc; inst_i = x.inst; reg1_data_i = x.r1; reg2_data_i = x.r2;
        ex_wreg_i = x.exw; ex_wd_i = x.exwd; ex_wdata_i = x.exdat; ex_is_load_i = x.exld;
        mem_wreg_i = x.memw; mem_wd_i = x.memwd; mem_wdata_i = x.memdat;
    endtask

    task automatic check_regs(input string tag, input out_t e);
        chk({tag, ".valid"},   ex_valid_o,   e.valid);
        chk({tag, ".pc"},      ex_pc_o,      e.pc);
        chk({tag, ".aluop"},   ex_aluop_o,   e.aluop);
        chk({tag, ".alusel"},  ex_alusel_o,  e.alusel);
        chk({tag, ".reg1"},    ex_reg1_o,    e.r1);
        chk({tag, ".reg2"},    ex_reg2_o,    e.r2);
        chk({tag, ".wd"},      ex_wd_o,      e.wd);
        chk({tag, ".wreg"},    ex_wreg_o,    e.wreg);
        chk({tag, ".illegal"}, ex_illegal_o, e.ill);
    endtask

    function automatic in_t mi(input logic [31:0] inst, input logic [31:0] pc,
                               input logic [31:0] r1, input logic [31:0] r2);
        in_t x = '0;
        x.vld = 1'b1; x.inst = inst; x.pc = pc; x.r1 = r1; x.r2 = r2;
        return x;
    endfunction

    function automatic out_t eo(input logic v, input logic [31:0] pc, input logic [7:0] aluop,
                                input logic [2:0] sel, input logic [31:0] r1, input logic [31:0] r2,
                                input logic [4:0] wd, input logic wreg, input logic ill, input logic sr);
        out_t o;
        o.stallreq = sr; o.valid = v; o.pc = pc; o.aluop = aluop; o.alusel = sel;
        o.r1 = r1; o.r2 = r2; o.wd = wd; o.wreg = wreg; o.ill = ill;
        return o;
    endfunction

    // Reference: the logic-op table is AND,OR,XOR,NOR at 8'h24.. in both the opcode and funct orderings.
    function automatic void model(input in_t x, input out_t cur, output out_t nxt,
                                  output logic sr, output logic rd1, output logic rd2);
        logic [5:0]  op = x.inst[31:26];
        logic [5:0]  fn = x.inst[5:0];
        logic [4:0]  src [2];
        logic [31:0] rf  [2];
        logic        en  [2];
        logic [31:0] val [2];
        logic [31:0] imm;
        bit is_imm, is_lui, is_rr, is_nop;
        is_imm = x.vld && op >= 6'd12 && op <= 6'd14;
        is_lui = x.vld && op == 6'd15;
        is_rr  = x.vld && op == 6'd0 && x.inst[10:6] == 5'd0 && fn >= 6'h24 && fn <= 6'h27;
        is_nop = x.vld && x.inst == 32'd0;
        rd1 = is_imm || is_lui || is_rr;
        rd2 = is_rr;
        imm = is_imm ? {16'h0, x.inst[15:0]} : is_lui ? {x.inst[15:0], 16'h0} : 32'h0;
        src[0] = is_lui ? 5'd0 : x.inst[25:21];
        src[1] = x.inst[20:16];
        rf[0] = x.r1; rf[1] = x.r2;
        en[0] = rd1;  en[1] = rd2;
        sr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (!en[k])                 val[k] = imm;
            else if (src[k] == 5'd0)    val[k] = 32'h0;
            else if (FWD && x.exw && x.exwd == src[k] && !x.exld) val[k] = x.exdat;
            else if (FWD && x.memw && x.memwd == src[k])          val[k] = x.memdat;
            else                        val[k] = rf[k];
            if (en[k] && src[k] != 5'd0) begin
                if (x.exw && x.exwd == src[k] && (x.exld || !FWD)) sr = 1'b1;
                if (!FWD && x.memw && x.memwd == src[k])           sr = 1'b1;
            end
        end
        sr = sr && x.vld;
        if (x.rst || x.flush || (!x.stall && sr)) begin
            nxt = '0;
        end else if (x.stall) begin
            nxt = cur;
        end else begin
            nxt.valid  = x.vld;
            nxt.pc     = x.pc;
            nxt.aluop  = is_imm ? 8'h24 + 8'(op - 6'd12) : is_lui ? 8'h25 : is_rr ? {2'b00, fn} : 8'h00;
            nxt.wreg   = is_imm || is_lui || is_rr;
            nxt.alusel = nxt.wreg ? 3'b001 : 3'b000;
            nxt.r1     = val[0];
            nxt.r2     = val[1];
            nxt.wd     = (is_imm || is_lui) ? x.inst[20:16] : x.inst[15:11];
            nxt.ill    = x.vld && !(is_imm || is_lui || is_rr || is_nop);
        end
        nxt.stallreq = 1'b0;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [4:0] rs = 5'($urandom_range(0, 7));
        logic [4:0] rt = 5'($urandom_range(0, 7));
        logic [4:0] rd = 5'($urandom_range(0, 7));
        logic [15:0] im = 16'($urandom);
        case ($urandom_range(0, 7))
            0: return {6'b001101, rs, rt, im};
            1: return {6'b001100, rs, rt, im};
            2: return {6'b001110, rs, rt, im};
            3: return {6'b001111, rs, rt, im};
            4: return {6'b000000, rs, rt, rd, 5'd0, 6'h24 + 6'($urandom_range(0, 3))};
            5: return {6'b000000, rs, rt, rd, 5'($urandom_range(0, 3)), 6'($urandom)};
            6: return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    vec_t v[16];

    initial begin
        out_t z  = '0;
        out_t zs = eo(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        out_t cur, nxt;
        in_t  x;
        logic sr, rd1, rd2;

        v[0].i = mi(I_ORI, 32'h100, 32'h1200, 0); v[0].i.rst = 1; v[0].e = z;
        v[1] = v[0];
        v[2].i = mi(I_ORI, 32'h104, 32'h1200, 0);
        v[2].e = eo(1, 32'h104, 8'h25, 1, 32'h1200, 32'hF0, 2, 1, 0, 0);
        v[3].i = mi(I_OR, 32'h108, 32'h1111, 32'h2222);
        v[3].i.exw = 1; v[3].i.exwd = 1; v[3].i.exdat = 32'hAAAA;
        v[3].i.memw = 1; v[3].i.memwd = 1; v[3].i.memdat = 32'h5555;
        v[3].e = FWD ? eo(1, 32'h108, 8'h25, 1, 32'hAAAA, 32'h2222, 3, 1, 0, 0) : zs;
        v[4].i = mi(I_AND, 32'h10C, 32'h00FF, 32'h1234);
        v[4].i.exw = 1; v[4].i.exwd = 0; v[4].i.exdat = 32'h9999;
        v[4].e = eo(1, 32'h10C, 8'h24, 1, 32'h00FF, 0, 4, 1, 0, 0);
        v[5].i = mi(I_XORI, 32'h110, 0, 0);
        v[5].i.exw = 1; v[5].i.exwd = 6; v[5].i.exld = 1;
        v[5].e = zs;
        v[6].i = mi(I_XORI, 32'h110, 0, 0);
        v[6].i.memw = 1; v[6].i.memwd = 6; v[6].i.memdat = 32'hBEEF;
        v[6].e = FWD ? eo(1, 32'h110, 8'h26, 1, 32'hBEEF, 1, 7, 1, 0, 0) : zs;
        v[7].i = mi(I_XORI, 32'h110, 32'hBEEF, 0);
        v[7].e = eo(1, 32'h110, 8'h26, 1, 32'hBEEF, 1, 7, 1, 0, 0);
        v[8].i = mi(I_LUI, 32'h114, 32'h5555, 0);
        v[8].i.exw = 1; v[8].i.exwd = 3; v[8].i.exld = 1;
        v[8].e = eo(1, 32'h114, 8'h25, 1, 0, 32'hABCD0000, 9, 1, 0, 0);
        v[9].i = mi(I_BAD, 32'h118, 32'h77, 32'h88);
        v[9].e = eo(1, 32'h118, 0, 0, 0, 0, 0, 0, 1, 0);
        v[10].i = mi(I_ORI, 32'h11C, 32'h1200, 0); v[10].i.stall = 1;
        v[10].e = v[9].e;
        v[11].i = v[10].i; v[11].i.flush = 1;
        v[11].e = z;
        v[12].i = mi(32'd0, 32'h120, 32'h33, 32'h44);
        v[12].e = eo(1, 32'h120, 0, 0, 0, 0, 0, 0, 0, 0);
        v[13].i = mi(I_ORI, 32'h124, 32'h1200, 0); v[13].i.vld = 0;
        v[13].e = eo(0, 32'h124, 0, 0, 0, 0, 0, 0, 0, 0);
        v[14].i = v[5].i; v[14].i.rst = 1; v[14].i.stall = 1;
        v[14].e = zs;
        v[15].i = mi(I_NOR, 32'h128, 32'hF0F0, 32'h0F0F);
        v[15].e = eo(1, 32'h128, 8'h27, 1, 32'hF0F0, 32'h0F0F, 3, 1, 0, 0);

        for (int n = 0; n < 16; n++) begin
            apply(v[n].i);
            #1;
            chk($sformatf("vec%0d.stallreq", n), stallreq_o, v[n].e.stallreq);
            @(posedge clk);
            #1;
            check_regs($sformatf("vec%0d", n), v[n].e);
        end

        cur = '0;
        for (int n = 0; n < 400; n++) begin
            x = '0;
            x.rst    = (n == 0) || ($urandom_range(0, 39) == 0);
            x.flush  = ($urandom_range(0, 9) == 0);
            x.stall  = ($urandom_range(0, 5) == 0);
            x.vld    = ($urandom_range(0, 7) != 0);
            x.pc     = $urandom;
            x.inst   = rand_inst();
            x.r1     = $urandom;
            x.r2     = $urandom;
            x.exw    = $urandom_range(0, 1);
            x.exwd   = 5'($urandom_range(0, 7));
            x.exdat  = $urandom;
            x.exld   = ($urandom_range(0, 3) == 0);
            x.memw   = $urandom_range(0, 1);
            x.memwd  = 5'($urandom_range(0, 7));
            x.memdat = $urandom;
            apply(x);
            #1;
            model(x, cur, nxt, sr, rd1, rd2);
            chk($sformatf("rnd%0d.stallreq", n), stallreq_o, sr);
            chk($sformatf("rnd%0d.read1", n), reg1_read_o, rd1);
            chk($sformatf("rnd%0d.read2", n), reg2_read_o, rd2);
            chk($sformatf("rnd%0d.addr", n), {reg1_addr_o, reg2_addr_o}, x.inst[25:16]);
            @(posedge clk);
            #1;
            check_regs($sformatf("rnd%0d", n), nxt);
            cur = nxt;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
